burst_write_master: RTL and testbench

BURST_WRITE_MASTER -- requirements
Module: burst_write_master

---
 rtl/burst_master_pkg.sv | 25 ++
 rtl/burst_write_master_fifo.sv | 78 +++++++
 rtl/burst_write_master.sv | 198 +++++++++++++++++++
 tb/tb_burst_write_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_master_pkg.sv
// Shared definitions for the burst write master.
//   state_e : FSM state encoding used by burst_write_master.
//   clog2   : ceiling log2 helper for elaboration-time width math.
package burst_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Ceiling log2 of a positive value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/burst_write_master_fifo.sv
// Synchronous show-ahead FIFO: pop_data always presents the head word.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset (empties FIFO)
//   push, push_data       : write request and data; dropped when full unless
//                           a pop happens in the same cycle
//   pop                   : consume head word; ignored when empty
//   pop_data              : head word (valid when !empty)
//   full, empty, usedw    : status, usedw is occupancy in words
module sync_showahead_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   usedw
);

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1'b1);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // legal exactly when it is paired with a pop.
  assign push_ok_s = push & (~full_s | pop);
  assign pop_ok_s  = pop & ~empty_s;

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_s;
  assign empty    = empty_s;
  assign usedw    = count_r;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/burst_write_master.sv
// Avalon-MM burst write master fed by a user-side show-ahead FIFO.
// A control_go pulse latches base/length; the FSM then issues bursts of up
// to MAXBURSTCOUNT words (one word in fixed-location mode) whenever enough
// words are buffered, so a started burst never stalls for data.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   control_*                    : start/configuration and done status
//   user_write_buffer/_data      : FIFO push side; user_buffer_full/_usedw status
//   master_*                     : Avalon-MM burst write master
module burst_write_master
  import burst_master_pkg::*;
#(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = DATAWIDTH / 8,
  parameter int ADDRESSWIDTH    = 32,
  parameter int MAXBURSTCOUNT   = 4,
  parameter int BURSTCOUNTWIDTH = 3,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    control_write_length,
  input  logic                       control_go,
  output logic                       control_done,
  output logic                       control_early_done,
  input  logic                       user_write_buffer,
  input  logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_buffer_full,
  output logic [FIFODEPTH_LOG2:0]    user_buffer_usedw,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest
);

  localparam int BE_LOG2 = clog2(BYTEENABLEWIDTH);
  localparam int TAIL_W  = (BE_LOG2 > 0) ? BE_LOG2 : 1;
  localparam logic [ADDRESSWIDTH-1:0]    BE_MASK = ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
  localparam logic [ADDRESSWIDTH-1:0]    AW_ONE  = ADDRESSWIDTH'(1'b1);
  localparam logic [ADDRESSWIDTH-1:0]    AW_MAXB = ADDRESSWIDTH'(MAXBURSTCOUNT);
  localparam logic [BURSTCOUNTWIDTH-1:0] BC_ONE  = BURSTCOUNTWIDTH'(1'b1);
  localparam logic [BURSTCOUNTWIDTH-1:0] BC_MAXB = BURSTCOUNTWIDTH'(MAXBURSTCOUNT);

  state_e                     state_r;
  state_e                     state_nxt_s;
  logic [ADDRESSWIDTH-1:0]    address_r;
  logic [ADDRESSWIDTH-1:0]    words_left_r;
  logic [TAIL_W-1:0]          tail_r;
  logic                       fixed_r;
  logic [BURSTCOUNTWIDTH-1:0] burst_len_r;
  logic [BURSTCOUNTWIDTH-1:0] beats_left_r;

  logic                       go_ok_s;
  logic [ADDRESSWIDTH-1:0]    len_tail_s;
  logic [ADDRESSWIDTH-1:0]    len_words_s;
  logic [BURSTCOUNTWIDTH-1:0] burst_len_calc_s;
  logic [ADDRESSWIDTH-1:0]    addr_step_s;
  logic                       accept_s;
  logic                       last_beat_s;
  logic                       data_ready_s;
  logic                       final_word_s;
  logic [BYTEENABLEWIDTH-1:0] tail_mask_s;

  logic [DATAWIDTH-1:0]       fifo_data_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [FIFODEPTH_LOG2:0]    fifo_usedw_s;

  sync_showahead_fifo #(
    .WIDTH      (DATAWIDTH),
    .DEPTH      (FIFODEPTH),
    .DEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (user_write_buffer),
    .push_data (user_buffer_data),
    .pop       (accept_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .usedw     (fifo_usedw_s)
  );

  assign go_ok_s  = control_go & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  // Word count rounds a partial trailing word up.
  assign len_tail_s  = control_write_length & BE_MASK;
  assign len_words_s = (control_write_length >> BE_LOG2)
                     + {{(ADDRESSWIDTH-1){1'b0}}, (len_tail_s != '0)};

  assign master_write = (state_r == ST_BURST);
  assign accept_s     = master_write & ~master_waitrequest;
  assign last_beat_s  = accept_s & (beats_left_r == BC_ONE);
  assign addr_step_s  = ADDRESSWIDTH'(burst_len_r) << BE_LOG2;
  assign data_ready_s = ~fifo_empty_s &
                        (ADDRESSWIDTH'(fifo_usedw_s) >= ADDRESSWIDTH'(burst_len_calc_s));

  // Next burst length from the words still owed.
  always_comb begin
    burst_len_calc_s = BC_ONE;
    if (fixed_r) begin
      burst_len_calc_s = BC_ONE;
    end else if (words_left_r >= AW_MAXB) begin
      burst_len_calc_s = BC_MAXB;
    end else begin
      burst_len_calc_s = BURSTCOUNTWIDTH'(words_left_r);
    end
  end

  // Byte-lane mask for a partial final word: low tail_r lanes enabled.
  always_comb begin
    tail_mask_s = '0;
    for (int i = 0; i < BYTEENABLEWIDTH; i++) begin
      tail_mask_s[i] = (TAIL_W'(i) < tail_r);
    end
  end

  assign final_word_s      = (words_left_r == AW_ONE) & (tail_r != '0);
  assign master_byteenable = final_word_s ? tail_mask_s : '1;
  assign master_address    = address_r;
  assign master_burstcount = burst_len_r;
  assign master_writedata  = fifo_data_s;
  assign control_done       = (state_r == ST_IDLE) | (state_r == ST_DONE);
  assign control_early_done = (words_left_r == '0);
  assign user_buffer_full   = fifo_full_s;
  assign user_buffer_usedw  = fifo_usedw_s;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (go_ok_s) begin
          state_nxt_s = (len_words_s == '0) ? ST_DONE : ST_WAIT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_WAIT: begin
        // Start only once the whole burst is buffered so write never drops.
        if (data_ready_s) begin
          state_nxt_s = ST_BURST;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_BURST: begin
        if (last_beat_s) begin
          state_nxt_s = (words_left_r == AW_ONE) ? ST_DONE : ST_WAIT;
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Transfer datapath: latch on go, size burst in WAIT, count beats in BURST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_r    <= '0;
      words_left_r <= '0;
      tail_r       <= '0;
      fixed_r      <= 1'b0;
      burst_len_r  <= '0;
      beats_left_r <= '0;
    end else if (go_ok_s) begin
      address_r    <= control_write_base;
      fixed_r      <= control_fixed_location;
      words_left_r <= len_words_s;
      tail_r       <= len_tail_s[TAIL_W-1:0];
    end else if (state_r == ST_WAIT) begin
      burst_len_r  <= burst_len_calc_s;
      beats_left_r <= burst_len_calc_s;
    end else if (accept_s) begin
      words_left_r <= words_left_r - AW_ONE;
      beats_left_r <= beats_left_r - BC_ONE;
      if (last_beat_s && !fixed_r) begin
        address_r <= address_r + addr_step_s;
      end
    end
  end

endmodule

// File: tb/tb_burst_write_master.sv
// Self-checking bench for burst_write_master (32-bit data, bursts of 4).
// Expected beats come from a queue model of the FIFO contents and the
// transfer rules (word count, burst split, address step, tail mask).
module tb_burst_write_master;

  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int AW  = 32;
  localparam int MBC = 4;
  localparam int BCW = 3;
  localparam int FD  = 32;
  localparam int FDL = 5;

  logic           clk;
  logic           reset_n;
  logic           control_fixed_location;
  logic [AW-1:0]  control_write_base;
  logic [AW-1:0]  control_write_length;
  logic           control_go;
  logic           control_done;
  logic           control_early_done;
  logic           user_write_buffer;
  logic [DW-1:0]  user_buffer_data;
  logic           user_buffer_full;
  logic [FDL:0]   user_buffer_usedw;
  logic [AW-1:0]  master_address;
  logic           master_write;
  logic [BEW-1:0] master_byteenable;
  logic [BCW-1:0] master_burstcount;
  logic [DW-1:0]  master_writedata;
  logic           master_waitrequest;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mod_q[$];

  burst_write_master #(
    .DATAWIDTH(DW), .BYTEENABLEWIDTH(BEW), .ADDRESSWIDTH(AW),
    .MAXBURSTCOUNT(MBC), .BURSTCOUNTWIDTH(BCW),
    .FIFODEPTH(FD), .FIFODEPTH_LOG2(FDL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .control_fixed_location(control_fixed_location),
    .control_write_base(control_write_base),
    .control_write_length(control_write_length),
    .control_go(control_go),
    .control_done(control_done),
    .control_early_done(control_early_done),
    .user_write_buffer(user_write_buffer),
    .user_buffer_data(user_buffer_data),
    .user_buffer_full(user_buffer_full),
    .user_buffer_usedw(user_buffer_usedw),
    .master_address(master_address),
    .master_write(master_write),
    .master_byteenable(master_byteenable),
    .master_burstcount(master_burstcount),
    .master_writedata(master_writedata),
    .master_waitrequest(master_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push n random words, one per cycle; model keeps only what fits.
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      user_write_buffer = 1'b1;
      user_buffer_data  = $urandom;
      if (mod_q.size() < FD) mod_q.push_back(user_buffer_data);
      @(negedge clk);
    end
    user_write_buffer = 1'b0;
  endtask

  // One transfer: preload npre words, pulse go, top up the FIFO from cycle
  // `hold` onward, stall with waitrequest at wr_pct percent, check every beat.
  task automatic run_xfer(input logic [31:0] base, input logic [31:0] len,
                          input logic fixed, input int npre, input int hold,
                          input int wr_pct);
    int words, tail, pushes_left, fifo_cnt, beats, acc_cyc, rem, exp_bc;
    bit in_burst, fin, acc, push_now;
    logic [31:0] exp_addr, cur_addr, exp_data;
    logic [BCW-1:0] cur_bc;
    logic [3:0] exp_be;
    words = int'((len + 32'd3) >> 2);
    tail  = int'(len & 32'd3);
    push_words(npre);
    chk("usedw_pre", 64'(user_buffer_usedw), 64'(mod_q.size()));
    pushes_left = words - mod_q.size();
    if (pushes_left < 0) pushes_left = 0;
    control_write_base = base;
    control_write_length = len;
    control_fixed_location = fixed;
    control_go = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
    fifo_cnt = mod_q.size();
    exp_addr = base; beats = 0; acc_cyc = -1; in_burst = 1'b0; fin = 1'b0;
    rem = 0; exp_bc = 0; cur_addr = '0; cur_bc = '0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      master_waitrequest = ($urandom_range(99) < wr_pct);
      acc = master_write && !master_waitrequest;
      chk("usedw", 64'(user_buffer_usedw), 64'(fifo_cnt));
      chk("early_done", 64'(control_early_done), 64'(beats == words));
      chk("done", 64'(control_done), 64'((words == 0) || (acc_cyc >= 0)));
      if (master_write && !in_burst) begin
        exp_bc = fixed ? 1 : ((words - beats) < MBC ? (words - beats) : MBC);
        chk("extra_write", 64'(beats < words), 64'(1));
        chk("burst_addr", 64'(master_address), 64'(exp_addr));
        chk("burstcount", 64'(master_burstcount), 64'(exp_bc));
        chk("data_buffered", 64'(fifo_cnt >= exp_bc), 64'(1));
        in_burst = 1'b1; rem = exp_bc;
        cur_addr = master_address; cur_bc = master_burstcount;
      end else if (in_burst) begin
        chk("write_held", 64'(master_write), 64'(1));
        chk("addr_stable", 64'(master_address), 64'(cur_addr));
        chk("bc_stable", 64'(master_burstcount), 64'(cur_bc));
      end
      if (acc) begin
        exp_data = (mod_q.size() > 0) ? mod_q.pop_front() : 32'hxxxx_xxxx;
        exp_be = (beats == words - 1 && tail != 0) ? 4'((1 << tail) - 1) : 4'hF;
        chk("wdata", 64'(master_writedata), 64'(exp_data));
        chk("byteenable", 64'(master_byteenable), 64'(exp_be));
        beats++; rem--;
        if (rem == 0) begin
          in_burst = 1'b0;
          if (!fixed) exp_addr = exp_addr + 32'(exp_bc * BEW);
        end
        if (beats == words) acc_cyc = cyc;
      end
      if (beats >= words && control_done && cyc >= 4) fin = 1'b1;
      fifo_cnt = fifo_cnt - int'(acc);
      push_now = (cyc >= hold) && (pushes_left > 0) && (fifo_cnt < FD);
      user_write_buffer = push_now;
      if (push_now) begin
        user_buffer_data = $urandom;
        mod_q.push_back(user_buffer_data);
        pushes_left--;
        fifo_cnt++;
      end
      @(negedge clk);
    end
    user_write_buffer = 1'b0;
    master_waitrequest = 1'b0;
    chk("finished", 64'(fin), 64'(1));
    chk("beat_count", 64'(beats), 64'(words));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_write"}, 64'(master_write), 64'(0));
    chk({tag, "_addr"}, 64'(master_address), 64'(0));
    chk({tag, "_bc"}, 64'(master_burstcount), 64'(0));
    chk({tag, "_be"}, 64'(master_byteenable), 64'(4'hF));
    chk({tag, "_done"}, 64'(control_done), 64'(1));
    chk({tag, "_early"}, 64'(control_early_done), 64'(1));
    chk({tag, "_full"}, 64'(user_buffer_full), 64'(0));
    chk({tag, "_usedw"}, 64'(user_buffer_usedw), 64'(0));
  endtask

  initial begin
    bit found;
    int len, words;
    logic [31:0] base;
    reset_n = 1'b0;
    control_fixed_location = 1'b0;
    control_write_base = '0;
    control_write_length = '0;
    control_go = 1'b0;
    user_write_buffer = 1'b0;
    user_buffer_data = '0;
    master_waitrequest = 1'b0;
    #1;
    chk_reset_state("rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_state("post_rst");

    // Two full bursts from preloaded data.
    run_xfer(32'h0000_1000, 32'd32, 1'b0, 8, 0, 0);
    // Partial final word: F, F, 3.
    run_xfer(32'h0000_2000, 32'd10, 1'b0, 3, 0, 0);
    // Fixed location: single-word writes at the base.
    run_xfer(32'h0000_3000, 32'd12, 1'b1, 3, 0, 0);
    // Starved start: 3 words buffered, rest arrive after a delay.
    run_xfer(32'h0000_4000, 32'd32, 1'b0, 3, 15, 0);
    // Zero length: done stays high, no write.
    run_xfer(32'h0000_6000, 32'd0, 1'b0, 0, 0, 0);
    // Random lengths and 50% waitrequest.
    for (int t = 0; t < 4; t++) begin
      len   = int'($urandom_range(120, 1));
      words = (len + 3) / 4;
      base  = $urandom & 32'hFFFF_FFFC;
      run_xfer(base, 32'(len), 1'b0, int'($urandom_range(32'(words), 0)),
               int'($urandom_range(5, 0)), 50);
    end
    // Address wraps past the top of the address space.
    run_xfer(32'hFFFF_FFF0, 32'd32, 1'b0, 8, 0, 0);

    // Reset in the second beat of a burst.
    push_words(8);
    control_write_base = 32'h0000_7000;
    control_write_length = 32'd32;
    control_fixed_location = 1'b0;
    control_go = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (master_write) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_burst_started", 64'(found), 64'(1));
    @(negedge clk);
    chk("rst_second_beat", 64'(master_write), 64'(1));
    reset_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    mod_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_state("after_mid_rst");
    run_xfer(32'h0000_8000, 32'd20, 1'b0, 5, 0, 30);

    // Fill the FIFO, overflow push is dropped, then drain it all.
    push_words(FD + 1);
    chk("fifo_full", 64'(user_buffer_full), 64'(1));
    chk("fifo_usedw_full", 64'(user_buffer_usedw), 64'(FD));
    run_xfer(32'h0000_9000, 32'd128, 1'b0, 0, 0, 25);
    chk("fifo_drained", 64'(user_buffer_usedw), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
